// File: rtl/gpio_lite_master_if.sv
// Command, response, interrupt and subunit bus signals of gpio_lite_master.
// The master modport is the block's view; slave is the surrounding system's view.
interface gpio_lite_master_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [5:0]  cmd_addr;
   logic [15:0] cmd_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_data;
   logic        rsp_ready;
   logic        irq_en;
   logic [15:0] irq_in;
   logic        irq_valid;
   logic [15:0] irq_status;
   logic        irq_ack;
   logic [7:0]  svc_count;
   logic        read;
   logic        write;
   logic [5:0]  addr;
   logic [15:0] wdata;
   logic [15:0] rdata;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
             irq_en, irq_in, irq_ack, rdata,
      output cmd_ready, rsp_valid, rsp_data, irq_valid, irq_status,
             svc_count, read, write, addr, wdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
             irq_en, irq_in, irq_ack, rdata,
      input  cmd_ready, rsp_valid, rsp_data, irq_valid, irq_status,
             svc_count, read, write, addr, wdata
   );
endinterface

// File: rtl/gpio_lite_master.sv
// Command/interrupt master for a GPIO subunit: single-beat reads and writes,
// plus automatic read-clear servicing of the subunit interrupt status register.
module gpio_lite_master #(
   parameter logic [5:0] GPR_INT_STATUS = 6'h20
) (
   input  logic               pclk,
   input  logic               reset,
   gpio_lite_master_if.master bus
);

   typedef enum logic [2:0] {IDLE, WR, RD, CAP, RSP, IRD, ICAP, IRQ} state_t;

   state_t      r_state, w_state_nxt;
   logic        r_read, w_read_nxt;
   logic        r_write, w_write_nxt;
   logic [5:0]  r_addr, w_addr_nxt;
   logic [15:0] r_wdata, w_wdata_nxt;
   logic        r_rsp_valid, w_rsp_valid_nxt;
   logic [15:0] r_rsp_data, w_rsp_data_nxt;
   logic        r_irq_valid, w_irq_valid_nxt;
   logic [15:0] r_irq_status, w_irq_status_nxt;
   logic [7:0]  r_svc_count, w_svc_count_nxt;
   logic        w_irq_start;
   logic        w_cmd_ready;

   // Interrupt service wins over any command presented in the same IDLE cycle.
   assign w_irq_start = (r_state == IDLE) && bus.irq_en && (bus.irq_in != 16'h0000);
   assign w_cmd_ready = (r_state == IDLE) && !w_irq_start && !reset;

   // NOTE: every next-value signal gets its default before the case statement,
   // so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt      = r_state;
      w_read_nxt       = 1'b0;
      w_write_nxt      = 1'b0;
      w_addr_nxt       = r_addr;
      w_wdata_nxt      = r_wdata;
      w_rsp_valid_nxt  = r_rsp_valid;
      w_rsp_data_nxt   = r_rsp_data;
      w_irq_valid_nxt  = r_irq_valid;
      w_irq_status_nxt = r_irq_status;
      w_svc_count_nxt  = r_svc_count;
      case (r_state)
         IDLE: begin
            if (w_irq_start) begin
               w_state_nxt = IRD;
               w_read_nxt  = 1'b1;
               w_addr_nxt  = GPR_INT_STATUS;
            end else if (bus.cmd_valid && w_cmd_ready) begin
               w_addr_nxt = bus.cmd_addr;
               if (bus.cmd_write) begin
                  w_state_nxt = WR;
                  w_write_nxt = 1'b1;
                  w_wdata_nxt = bus.cmd_wdata;
               end else begin
                  w_state_nxt = RD;
                  w_read_nxt  = 1'b1;
               end
            end
         end
         WR:  w_state_nxt = IDLE;
         RD:  w_state_nxt = CAP;
         CAP: begin
            w_state_nxt     = RSP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_data_nxt  = bus.rdata;
         end
         RSP: begin
            if (bus.rsp_ready) begin
               w_state_nxt     = IDLE;
               w_rsp_valid_nxt = 1'b0;
            end
         end
         IRD: w_state_nxt = ICAP;
         ICAP: begin
            w_irq_status_nxt = bus.rdata;
            // A status that cleared before the read is not counted as a service.
            if (bus.rdata != 16'h0000) begin
               w_state_nxt     = IRQ;
               w_irq_valid_nxt = 1'b1;
               w_svc_count_nxt = r_svc_count + 8'd1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         IRQ: begin
            if (bus.irq_ack) begin
               w_state_nxt     = IDLE;
               w_irq_valid_nxt = 1'b0;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values computed above.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_read       <= 1'b0;
         r_write      <= 1'b0;
         r_addr       <= 6'h00;
         r_wdata      <= 16'h0000;
         r_rsp_valid  <= 1'b0;
         r_rsp_data   <= 16'h0000;
         r_irq_valid  <= 1'b0;
         r_irq_status <= 16'h0000;
         r_svc_count  <= 8'h00;
      end else begin
         r_state      <= w_state_nxt;
         r_read       <= w_read_nxt;
         r_write      <= w_write_nxt;
         r_addr       <= w_addr_nxt;
         r_wdata      <= w_wdata_nxt;
         r_rsp_valid  <= w_rsp_valid_nxt;
         r_rsp_data   <= w_rsp_data_nxt;
         r_irq_valid  <= w_irq_valid_nxt;
         r_irq_status <= w_irq_status_nxt;
         r_svc_count  <= w_svc_count_nxt;
      end
   end

   assign bus.cmd_ready  = w_cmd_ready;
   assign bus.read       = r_read;
   assign bus.write      = r_write;
   assign bus.addr       = r_addr;
   assign bus.wdata      = r_wdata;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_data   = r_rsp_data;
   assign bus.irq_valid  = r_irq_valid;
   assign bus.irq_status = r_irq_status;
   assign bus.svc_count  = r_svc_count;

endmodule
